// File: rtl/gf2m_mul_arbiter.sv
// Round-robin front end for one shared digit-serial GF(2^m) multiplier core.
// Runs one operation at a time: clear the core, stream b MSB digit first, wait for done, return the tagged result.
module gf2m_mul_arbiter #(
  parameter int DIGITAL    = 32,
  parameter int DATA_WIDTH = 163,
  parameter int NDIG       = DATA_WIDTH / DIGITAL + 1,
  parameter int BWIDTH     = NDIG * DIGITAL,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_g,
  input  logic [BWIDTH-1:0]     req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_g,
  input  logic [BWIDTH-1:0]     req1_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  core_rst_n,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_a,
  output logic [DATA_WIDTH-1:0] core_g,
  output logic [DIGITAL-1:0]    core_b,
  input  logic [DATA_WIDTH-1:0] core_t,
  input  logic                  core_done,
  output logic [2:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // req*_ready is high only in IDLE and only for the granted requester; resp_valid holds until resp_ready.

  localparam int DCW = $clog2(NDIG + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [BWIDTH-1:0]     b_q, b_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  id_q, id_d;
  logic                  prio_q, prio_d;
  logic                  rerr_q, rerr_d;
  logic                  crst_n_q, crst_n_d;
  logic [DCW-1:0]        dig_q, dig_d;
  logic [TCW-1:0]        to_q, to_d;

  logic gnt_valid;
  logic gnt_id;
  logic last_digit;
  logic timed_out;

  // Priority pointer only matters when both requesters are valid.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = prio_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign last_digit = (dig_q == DCW'(NDIG - 1));
  assign timed_out  = (to_q == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_valid) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FEED;
      S_FEED:  if (last_digit) state_d = S_WAIT;
      S_WAIT:  if (core_done || timed_out) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_start = 1'b0;
    core_b     = '0;
    resp_valid = 1'b0;
    core_a     = (state_q != S_IDLE) ? a_q : '0;
    core_g     = (state_q != S_IDLE) ? g_q : '0;
    case (state_q)
      S_IDLE: begin
        req0_ready = !rst && gnt_valid && !gnt_id;
        req1_ready = !rst && gnt_valid && gnt_id;
      end
      S_FEED: begin
        core_start = (dig_q == '0);
        core_b     = b_q[BWIDTH-1 -: DIGITAL];
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    g_d     = g_q;
    b_d     = b_q;
    id_d    = id_q;
    prio_d  = prio_q;
    dig_d   = dig_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          a_d   = gnt_id ? req1_a : req0_a;
          g_d   = gnt_id ? req1_g : req0_g;
          b_d   = gnt_id ? req1_b : req0_b;
          id_d  = gnt_id;
          dig_d = '0;
          to_d  = '0;
        end
      end
      S_FEED: begin
        // Shifting after each digit puts digit k at the top on FEED cycle k.
        b_d   = b_q << DIGITAL;
        dig_d = dig_q + DCW'(1);
        to_d  = '0;
      end
      S_WAIT: begin
        to_d = to_q + TCW'(1);
        if (core_done) begin
          rdata_d = core_t;
          rerr_d  = 1'b0;
        end else if (timed_out) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) prio_d = ~id_q;
      end
      default: ;
    endcase
  end

  // Core reset is registered so it is glitch-free; low for exactly the CLEAR cycle.
  assign crst_n_d = (state_d != S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      prio_q   <= 1'b0;
      dig_q    <= '0;
      to_q     <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      crst_n_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      g_q      <= g_d;
      b_q      <= b_d;
      id_q     <= id_d;
      prio_q   <= prio_d;
      dig_q    <= dig_d;
      to_q     <= to_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      crst_n_q <= crst_n_d;
    end
  end

  assign resp_id     = id_q;
  assign resp_data   = rdata_q;
  assign resp_err    = rerr_q;
  assign core_rst_n  = crst_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// Bench for gf2m_mul_arbiter: behavioural multiplier core, two requesters, scoreboard on the response port.
module tb_gf2m_mul_arbiter;

  localparam int DIG  = 32;
  localparam int DW   = 163;
  localparam int NDIG = 6;
  localparam int BW   = 192;
  localparam int TO   = 255;
  localparam int RW   = DW + 2;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_g, req1_a, req1_g;
  logic [BW-1:0] req0_b, req1_b;
  logic          resp_valid, resp_ready, resp_id, resp_err;
  logic [DW-1:0] resp_data;
  logic          core_rst_n, core_start, core_done;
  logic [DW-1:0] core_a, core_g, core_t;
  logic [DIG-1:0] core_b;
  logic [2:0]    dbg_state;

  logic [RW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            core_delay = 2;
  bit            spur_done  = 1'b0;

  gf2m_mul_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_g(req0_g), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_g(req1_g), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .core_rst_n(core_rst_n), .core_start(core_start),
    .core_a(core_a), .core_g(core_g), .core_b(core_b),
    .core_t(core_t), .core_done(core_done),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polynomial-basis product modulo x^163 + g.
  function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [BW-1:0] b,
                                           input logic [DW-1:0] g);
    logic [DW-1:0] r;
    r = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      r = r[DW-1] ? ({r[DW-2:0], 1'b0} ^ g) : {r[DW-2:0], 1'b0};
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] mk_exp(input logic id, input logic [DW-1:0] a,
                                           input logic [DW-1:0] g, input logic [BW-1:0] b);
    if (core_delay <= 0 || core_delay > TO) return {id, 1'b1, {DW{1'b0}}};
    return {id, 1'b0, gf_mul(a, b, g)};
  endfunction

  function automatic logic [DW-1:0] rnd_dw();
    logic [BW-1:0] r;
    for (int i = 0; i < NDIG; i++) r[i*DIG +: DIG] = $urandom;
    return r[DW-1:0];
  endfunction

  // Behavioural core: collects digits after start, raises done core_delay-1 cycles into WAIT.
  initial begin
    logic [BW-1:0] cm_b;
    int cm_cnt;
    int cm_wait;
    core_done = 1'b0;
    core_t    = '0;
    cm_b      = '0;
    cm_cnt    = 0;
    cm_wait   = 0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!core_rst_n) begin
        cm_b = '0; cm_cnt = 0; cm_wait = 0;
      end else if (core_start || (cm_cnt > 0 && cm_cnt < NDIG)) begin
        cm_b = {cm_b[BW-DIG-1:0], core_b};
        cm_cnt++;
        if (spur_done && cm_cnt == 3) begin
          core_done = 1'b1;
          core_t    = '1;
        end
      end else if (cm_cnt == NDIG) begin
        if (core_delay > 0 && cm_wait == core_delay - 1) begin
          core_done = 1'b1;
          core_t    = gf_mul(core_a, cm_b, core_g);
        end
        cm_wait++;
      end
    end
  end

  // Scoreboard: compare each response on its handshake cycle; readies must be exclusive.
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("resp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("resp", {resp_id, resp_err, resp_data}, e);
        end
      end
      if (req0_ready || req1_ready) check_eq("ready_excl", req0_ready && req1_ready, 0);
    end
  end

  // Driver tasks
  task automatic drive_req(input logic id, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] g, input logic [BW-1:0] b);
    if (id) begin
      req1_valid = v; req1_a = a; req1_g = g; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_g = g; req0_b = b;
    end
  endtask

  // Returns on the negedge of the CLEAR cycle (one cycle after the handshake).
  task automatic issue(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] g,
                       input logic [BW-1:0] b, input bit push);
    bit done;
    done = 1'b0;
    drive_req(id, 1'b1, a, g, b);
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        if (push) exp_q.push_back(mk_exp(id, a, g, b));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check_eq("handshake_timeout", 0, 1);
    drive_req(id, 1'b0, a, g, b);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("resp_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int            lat;
    logic [DW-1:0] a0, g0, a1, g1;
    logic [BW-1:0] b0, b1;
    logic          gid;
    bit            any_resp;

    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_g = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_g = '0; req1_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_resp_id", resp_id, 0);
    check_eq("rst_core_rst_n", core_rst_n, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_core_b", core_b, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_core_rst_n", core_rst_n, 1);
    check_eq("idle_ready0", req0_ready, 0);

    // Single op from requester 0 with minimum latency
    issue(1'b0, DW'(3), DW'('hC9), BW'(5), 1'b1);
    check_eq("clear_state", dbg_state, 1);
    check_eq("clear_core_rst_n", core_rst_n, 0);
    wait_valid(lat);
    check_eq("single_latency", lat, 1 + NDIG + 2 + 1);
    wait_resp();

    // Digit order, start pulse, spurious done during FEED ignored
    spur_done = 1'b1;
    a0 = rnd_dw();
    b0 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    issue(1'b0, a0, DW'('hC9), b0, 1'b1);
    for (int k = 0; k < NDIG; k++) begin
      @(negedge clk);
      check_eq("feed_digit", core_b, k + 1);
      check_eq("feed_start", core_start, (k == 0) ? 1 : 0);
      check_eq("feed_core_a", core_a, a0);
    end
    @(negedge clk);
    check_eq("wait_state", dbg_state, 3);
    check_eq("wait_core_b", core_b, 0);
    wait_resp();
    spur_done = 1'b0;

    // Timeout, then done coinciding with the timeout, then a normal op
    core_delay = -1;
    issue(1'b0, rnd_dw(), rnd_dw(), BW'(rnd_dw()), 1'b1);
    wait_valid(lat);
    check_eq("timeout_latency", lat, 1 + NDIG + TO + 1);
    wait_resp();
    core_delay = TO;
    issue(1'b1, rnd_dw(), rnd_dw(), BW'(rnd_dw()), 1'b1);
    wait_valid(lat);
    check_eq("edge_latency", lat, 1 + NDIG + TO + 1);
    wait_resp();
    core_delay = 2;
    issue(1'b0, rnd_dw(), rnd_dw(), BW'(rnd_dw()), 1'b1);
    wait_resp();

    // Both requesters valid from reset: service order 0,1,0,1
    do_reset();
    a0 = rnd_dw(); g0 = rnd_dw(); b0 = BW'(rnd_dw());
    a1 = rnd_dw(); g1 = rnd_dw(); b1 = BW'(rnd_dw());
    drive_req(1'b0, 1'b1, a0, g0, b0);
    drive_req(1'b1, 1'b1, a1, g1, b1);
    for (int n = 0; n < 4; n++) begin
      gid = 1'b0;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (req0_ready || req1_ready) break;
        @(negedge clk);
      end
      gid = req1_ready;
      check_eq("rr_order", gid, n % 2);
      exp_q.push_back(gid ? mk_exp(1'b1, a1, g1, b1) : mk_exp(1'b0, a0, g0, b0));
      @(negedge clk);
      if (gid) begin
        a1 = rnd_dw(); g1 = rnd_dw(); b1 = BW'(rnd_dw());
        drive_req(1'b1, n < 3, a1, g1, b1);
      end else begin
        a0 = rnd_dw(); g0 = rnd_dw(); b0 = BW'(rnd_dw());
        drive_req(1'b0, n < 3, a0, g0, b0);
      end
    end
    drive_req(1'b0, 1'b0, a0, g0, b0);
    drive_req(1'b1, 1'b0, a1, g1, b1);
    wait_resp();

    // Backpressure with requester 1 waiting
    resp_ready = 1'b0;
    issue(1'b0, rnd_dw(), rnd_dw(), BW'(rnd_dw()), 1'b1);
    wait_valid(lat);
    a1 = rnd_dw(); g1 = rnd_dw(); b1 = BW'(rnd_dw());
    drive_req(1'b1, 1'b1, a1, g1, b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("bp_valid", resp_valid, 1);
      check_eq("bp_resp", {resp_id, resp_err, resp_data}, exp_q[0]);
      check_eq("bp_ready1", req1_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_accept_ready1", req1_ready, 1);
    exp_q.push_back(mk_exp(1'b1, a1, g1, b1));
    @(negedge clk);
    drive_req(1'b1, 1'b0, a1, g1, b1);
    check_eq("bp_accept_state", dbg_state, 1);
    wait_resp();

    // Reset during FEED cycle 3: operation discarded, then re-issued
    a0 = rnd_dw(); g0 = rnd_dw(); b0 = BW'(rnd_dw());
    issue(1'b0, a0, g0, b0, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("mid_feed_state", dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_state", dbg_state, 0);
    check_eq("mid_rst_core_rst_n", core_rst_n, 0);
    check_eq("mid_rst_resp_valid", resp_valid, 0);
    check_eq("mid_rst_core_b", core_b, 0);
    rst = 1'b0;
    any_resp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_resp |= resp_valid;
    end
    check_eq("mid_rst_no_resp", any_resp, 0);
    issue(1'b0, a0, g0, b0, 1'b1);
    wait_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
